cypher_transmitter: RTL and testbench
=====================================

# cypher_transmitter

Serial source for the cypher-detection path. Latches a 16-bit cypher and repeat count on `start`, then emits the cypher as a stream of 4-bit nibbles on `seq_out` with a valid/ready handshake. Filler gaps separate repetitions. It drives the `seq_input` side of the detector, both in the bench and in on-chip loopback.

## Interface
- `GAP_CYCLES`, default 2: idle cycles between repetitions, range 0..15.
- `FILL`, default 4'hF: nibble driven on `seq_out` while not valid.
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: one clock; reset is asynchronous and active-low.
- `start`, input, 1: request a transmission. Sampled only in IDLE.
- `fullcypher`, input, 16: cypher. Latched on accepted `start`.
- `repeat`, input, 6: number of cypher repetitions, 0..63. Latched on accepted `start`.
- `seq_ready`, input, 1: consumer accepts the current nibble.
- `seq_out`, output, 4: current nibble.
- `seq_valid`, output, 1: `seq_out` holds a cypher nibble.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `sent_count`, output, 10: completed cypher repetitions since the last accepted `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - SEND: presents nibbles.
  - GAP: runs the filler period.
  - DONE: raises the completion pulse for one cycle.
- IDLE: `start`=1 latches `fullcypher`, `repeat`, clears `sent_count`, and moves to SEND. If `repeat`=0, it moves to DONE instead.
- Nibble order:
  - index 0 is `fullcypher[15:12]`, index 1 is `[11:8]`, index 2 is `[7:4]`, index 3 is `[3:0]`.
  - `seq_out` is the latched nibble at the current index.
  - `seq_out` is `FILL` whenever `seq_valid`=0.
- SEND:
  - `seq_valid`=1.
  - A transfer occurs on a cycle where `seq_valid` and `seq_ready` are both high. The index advances only on a transfer.
  - While `seq_ready`=0, `seq_out` holds steady.
- Transfer of index 3:
  - `sent_count` increments. It saturates at 1023.
  - The remaining repeat count decrements.
  - If the remaining count reaches 0, go to DONE.
  - Otherwise go to GAP if `GAP_CYCLES`>0, else stay in SEND with index 0.
- GAP:
  - `seq_valid`=0 for exactly `GAP_CYCLES` cycles, counted independently of `seq_ready`.
  - Then return to SEND with index 0.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored, including in DONE.
- Changes on `fullcypher` or `repeat` after latching have no effect.
- Reset asserted mid-operation: all state and outputs take their reset values immediately, with no `done` pulse. Operation resumes in IDLE on the first edge after deassertion.

## Timing
- Reset values: state IDLE, `seq_out`=`FILL`, `seq_valid`=0, `busy`=0, `done`=0, `sent_count`=0, index 0.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Start latency: `start` at edge N, then `seq_valid`=1 with nibble 0 from cycle N+1.
- Throughput with `seq_ready` held high:
  - one nibble per cycle;
  - one repetition takes 4+`GAP_CYCLES` cycles;
  - the last repetition is followed directly by DONE.
- Total cycles from `start` to the `done` pulse, with `seq_ready` high and `repeat`=R≥1: 4R+(R−1)·`GAP_CYCLES`+1.
- With `repeat`=0, `done` is high in cycle N+1.
- `sent_count` updates on the edge of the index-3 transfer. It is valid at the latest in the DONE cycle and holds until the next accepted `start`.

## Structure
- Package `cypher_pkg` holds:
  - `NIBBLE_W`=4, `CYPHER_W`=16, `SUM_W`=10, `REP_W`=6;
  - the state enum `tx_state_t` (IDLE, SEND, GAP, DONE).
- Sub-module `cypher_nibble_mux`: purely combinational. It selects the latched-cypher nibble by a 2-bit index, and `FILL` when invalid.
- The FSM, counters and handshake stay in `cypher_transmitter`.

## Test plan
- Single shot, `GAP_CYCLES`=2, `seq_ready`=1, `fullcypher`=16'hA5C3, `repeat`=1:
  - `seq_out` is A,5,C,3 on cycles 1–4;
  - `done` in cycle 5;
  - `sent_count`=1.
- Back-pressure, `fullcypher`=16'h1234, `repeat`=1, `seq_ready` low on cycles 2–3:
  - `seq_out` holds 2 through the stall;
  - sequence is 1,2,2,2,3,4;
  - `done` in cycle 7.
- Repeats, `repeat`=3, `GAP_CYCLES`=2:
  - pattern is 4 nibbles + 2 `FILL` cycles (`seq_valid`=0), repeated, ending in 4 nibbles;
  - `done` in cycle 17;
  - `sent_count`=3.
- `repeat`=0:
  - `done` in cycle 1;
  - `seq_valid` never rises;
  - `sent_count`=0.
- `start` pulsed mid-SEND and `fullcypher` changed mid-SEND: the stream is unchanged from the latched values.
- `reset` asserted during the third nibble:
  - outputs go to reset values asynchronously;
  - no `done` pulse;
  - a fresh `start` after release transmits correctly from nibble 0.

Source files
------------

// File: rtl/cypher_pkg.sv
// Shared widths and FSM state type for the cypher transmit path.
package cypher_pkg;
   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned CYPHER_W = 16;
   localparam int unsigned SUM_W    = 10;
   localparam int unsigned REP_W    = 6;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      DONE
   } tx_state_t;
endpackage

// File: rtl/cypher_transmitter_if.sv
// Nibble stream with valid/ready handshake between transmitter and detector.
interface cypher_transmitter_if;
   import cypher_pkg::*;

   logic [NIBBLE_W-1:0] seq_out;
   logic                seq_valid;
   logic                seq_ready;

   modport master (output seq_out, output seq_valid, input seq_ready);
   modport slave  (input seq_out, input seq_valid, output seq_ready);
endinterface

// File: rtl/cypher_nibble_mux.sv
// Selects one nibble of the latched cypher, MSB nibble first; FILL when not valid.
module cypher_nibble_mux
   import cypher_pkg::*;
#(
   parameter logic [NIBBLE_W-1:0] FILL = 4'hF
) (
   input  logic [CYPHER_W-1:0] cypher,
   input  logic [1:0]          idx,
   input  logic                valid,
   output logic [NIBBLE_W-1:0] nibble
);
   always_comb begin
      nibble = FILL;
      if (valid) begin
         unique case (idx)
            2'd0: nibble = cypher[15:12];
            2'd1: nibble = cypher[11:8];
            2'd2: nibble = cypher[7:4];
            2'd3: nibble = cypher[3:0];
         endcase
      end
   end
endmodule

// File: rtl/cypher_transmitter.sv
// Latches a cypher and repeat count on start, then streams it as nibbles with filler gaps.
module cypher_transmitter
   import cypher_pkg::*;
#(
   parameter int unsigned         GAP_CYCLES = 2,
   parameter logic [NIBBLE_W-1:0] FILL       = 4'hF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CYPHER_W-1:0]  fullcypher,
   input  logic [REP_W-1:0]     repeat_n,
   cypher_transmitter_if.master seq,
   output logic                 busy,
   output logic                 done,
   output logic [SUM_W-1:0]     sent_count
);
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   tx_state_t            state, state_next;
   logic [CYPHER_W-1:0]  cypher;
   logic [REP_W-1:0]     remaining;
   logic [1:0]           idx;
   logic [3:0]           gap_cnt;
   logic                 xfer;
   logic                 last_xfer;

   assign xfer      = (state == SEND) && seq.seq_ready;
   assign last_xfer = xfer && (idx == 2'd3);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = (repeat_n == '0) ? DONE : SEND;
         SEND: begin
            if (last_xfer) begin
               if (remaining == REP_W'(1)) state_next = DONE;
               else if (GAP_CYCLES > 0)    state_next = GAP;
               else                        state_next = SEND;
            end
         end
         GAP:  if (gap_cnt == GAP_LAST) state_next = SEND;
         DONE: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cypher     <= '0;
         remaining  <= '0;
         idx        <= '0;
         gap_cnt    <= '0;
         sent_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  cypher     <= fullcypher;
                  remaining  <= repeat_n;
                  idx        <= '0;
                  sent_count <= '0;
               end
            end
            SEND: begin
               gap_cnt <= '0;
               // idx wraps 3 -> 0, so the next repetition always begins at nibble 0
               if (xfer) idx <= idx + 2'd1;
               if (last_xfer) begin
                  remaining <= remaining - REP_W'(1);
                  if (sent_count != '1) sent_count <= sent_count + SUM_W'(1);
               end
            end
            GAP:  gap_cnt <= gap_cnt + 4'd1;
            DONE: ;
         endcase
      end
   end

   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign seq.seq_valid = (state == SEND);

   cypher_nibble_mux #(.FILL(FILL)) u_mux (
      .cypher (cypher),
      .idx    (idx),
      .valid  (state == SEND),
      .nibble (seq.seq_out)
   );
endmodule

// File: tb/tb_cypher_transmitter.sv
// Directed checks of cypher_transmitter: shot, back-pressure, repeats, zero repeat, ignored start, reset.
module tb_cypher_transmitter;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] fullcypher = '0;
   logic [5:0]  repeat_n = '0;
   logic        busy, done;
   logic [9:0]  sent_count;
   int unsigned tests = 0;
   int unsigned fails = 0;

   cypher_transmitter_if seq_if();

   cypher_transmitter #(.GAP_CYCLES(2), .FILL(4'hF)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .fullcypher (fullcypher),
      .repeat_n   (repeat_n),
      .seq        (seq_if.master),
      .busy       (busy),
      .done       (done),
      .sent_count (sent_count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [15:0] c, input logic [5:0] r);
      fullcypher = c;
      repeat_n   = r;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   logic [3:0]  bp_exp [6] = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h3, 4'h4};
   logic [3:0]  a5_exp [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
   logic [3:0]  c0_exp [4] = '{4'hC, 4'h0, 4'hD, 4'hE};
   logic [3:0]  b2_exp [4] = '{4'h6, 4'hB, 4'h2, 4'hD};
   logic [15:0] rep_cy = 16'h9E07;
   int          pos;
   logic [3:0]  exp_nib;

   initial begin
      seq_if.seq_ready = 1'b1;

      // reset values while reset is held
      #2;
      check("rst_valid", 16'(seq_if.seq_valid), 16'h0);
      check("rst_out",   16'(seq_if.seq_out),   16'hF);
      check("rst_busy",  16'(busy),             16'h0);
      check("rst_done",  16'(done),             16'h0);
      check("rst_count", 16'(sent_count),       16'h0);
      tick();
      @(negedge clock) reset = 1'b1;
      tick();
      check("idle_busy", 16'(busy), 16'h0);

      // single shot
      launch(16'hA5C3, 6'd1);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("shot_valid%0d", c + 1), 16'(seq_if.seq_valid), 16'h1);
         check($sformatf("shot_out%0d", c + 1),   16'(seq_if.seq_out),   16'(a5_exp[c]));
         check($sformatf("shot_done%0d", c + 1),  16'(done),             16'h0);
         tick();
      end
      check("shot_done5",  16'(done),       16'h1);
      check("shot_count",  16'(sent_count), 16'd1);
      check("shot_valid5", 16'(seq_if.seq_valid), 16'h0);
      tick();
      check("shot_done6",  16'(done),       16'h0);
      check("shot_busy6",  16'(busy),       16'h0);
      check("shot_hold",   16'(sent_count), 16'd1);

      // back-pressure on cycles 2-3
      launch(16'h1234, 6'd1);
      for (int c = 1; c <= 6; c++) begin
         seq_if.seq_ready = !(c == 2 || c == 3);
         check($sformatf("bp_out%0d", c), 16'(seq_if.seq_out), 16'(bp_exp[c-1]));
         tick();
      end
      seq_if.seq_ready = 1'b1;
      check("bp_done7",  16'(done),       16'h1);
      check("bp_count",  16'(sent_count), 16'd1);
      tick();

      // three repeats with 2-cycle gaps; ready dropped in gaps, inputs changed after latch
      launch(rep_cy, 6'd3);
      for (int c = 1; c <= 16; c++) begin
         pos = (c - 1) % 6;
         seq_if.seq_ready = (pos < 4);
         if (c == 2) begin
            fullcypher = 16'hFFFF;
            repeat_n   = 6'd0;
         end
         exp_nib = (pos < 4) ? 4'(rep_cy >> (12 - 4 * pos)) : 4'hF;
         check($sformatf("rep_valid%0d", c), 16'(seq_if.seq_valid), 16'((pos < 4) ? 1 : 0));
         check($sformatf("rep_out%0d", c),   16'(seq_if.seq_out),   16'(exp_nib));
         check($sformatf("rep_done%0d", c),  16'(done),             16'h0);
         tick();
      end
      seq_if.seq_ready = 1'b1;
      check("rep_done17", 16'(done),       16'h1);
      check("rep_count",  16'(sent_count), 16'd3);
      tick();

      // repeat = 0
      launch(16'h7777, 6'd0);
      check("zero_done1",  16'(done),             16'h1);
      check("zero_valid1", 16'(seq_if.seq_valid), 16'h0);
      check("zero_count",  16'(sent_count),       16'd0);
      tick();
      check("zero_done2",  16'(done),             16'h0);
      check("zero_valid2", 16'(seq_if.seq_valid), 16'h0);
      check("zero_busy2",  16'(busy),             16'h0);

      // start and fullcypher changed mid-SEND, start held through DONE
      launch(16'h6B2D, 6'd1);
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin
            start      = 1'b1;
            fullcypher = 16'h0000;
            repeat_n   = 6'd5;
         end
         check($sformatf("ign_out%0d", c), 16'(seq_if.seq_out), 16'(b2_exp[c-1]));
         tick();
      end
      check("ign_done5", 16'(done),       16'h1);
      check("ign_count", 16'(sent_count), 16'd1);
      tick();
      start = 1'b0;
      check("ign_busy6", 16'(busy), 16'h0);
      tick();
      check("ign_busy7", 16'(busy), 16'h0);

      // reset asserted during the third nibble
      launch(16'hC0DE, 6'd2);
      tick();
      tick();
      check("rst3_out", 16'(seq_if.seq_out), 16'hD);
      #2 reset = 1'b0;
      #1;
      check("arst_valid", 16'(seq_if.seq_valid), 16'h0);
      check("arst_out",   16'(seq_if.seq_out),   16'hF);
      check("arst_busy",  16'(busy),             16'h0);
      check("arst_count", 16'(sent_count),       16'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("arst_nodone%0d", c), 16'(done), 16'h0);
      end
      @(negedge clock) reset = 1'b1;
      launch(16'hC0DE, 6'd1);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("post_valid%0d", c + 1), 16'(seq_if.seq_valid), 16'h1);
         check($sformatf("post_out%0d", c + 1),   16'(seq_if.seq_out),   16'(c0_exp[c]));
         tick();
      end
      check("post_done5", 16'(done),       16'h1);
      check("post_count", 16'(sent_count), 16'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
